// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - opcodes, flag indices, FSM states and flag-update helpers for alu_sched
package alu_sched_pkg;

    localparam logic [3:0] OP_RED    = 4'd0;
    localparam logic [3:0] OP_SLL    = 4'd1;
    localparam logic [3:0] OP_SRA    = 4'd2;
    localparam logic [3:0] OP_PADDSB = 4'd3;
    localparam logic [3:0] OP_ROR    = 4'd4;
    localparam logic [3:0] OP_LW     = 4'd5;
    localparam logic [3:0] OP_SW     = 4'd6;
    localparam logic [3:0] OP_LHB    = 4'd7;
    localparam logic [3:0] OP_LLB    = 4'd8;
    localparam logic [3:0] OP_ADD    = 4'd9;
    localparam logic [3:0] OP_SUB    = 4'd10;
    localparam logic [3:0] OP_XOR    = 4'd11;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // Arithmetic ops refresh all three flags
    function automatic logic sets_znv(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Logic/shift ops refresh only the zero flag
    function automatic logic sets_z(input logic [3:0] op);
        return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// rtl/alu_sched_rr_arb2.sv - two-way round-robin arbiter, one-hot grant
module rr_arb2
    import alu_sched_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // A lone requester always wins; on contention the one not granted last time wins
    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - shares one ALU between two requesters; optional counters under ALU_SCHED_PERF_EN
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int OP_W        = 4,
    parameter int DATA_W      = 16,
    parameter bit FIRST_GRANT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_src1,
    input  logic [DATA_W-1:0] req0_src2,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_src1,
    input  logic [DATA_W-1:0] req1_src2,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_result,
    output logic              resp0_err,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_result,
    output logic              resp1_err,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [2:0]        alu_flags,
    output logic [2:0]        flags
`ifdef ALU_SCHED_PERF_EN
    ,
    output logic [15:0]       perf_grant0,
    output logic [15:0]       perf_grant1,
    output logic [15:0]       perf_bp
`endif
);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              own_q, own_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] src1_q, src1_d;
    logic [DATA_W-1:0] src2_q, src2_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              err_q, err_d;
    logic [2:0]        flags_q, flags_d;
    logic [1:0]        grant;
    logic              owner_ready;
    logic              unused_alu_n;

    // The scheduler derives N from the result MSB rather than the ALU's N output
    assign unused_alu_n = alu_flags[FLAG_N];

    rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_q),
        .grant      (grant)
    );

    assign req0_ready  = (state_q == ST_IDLE) && grant[0];
    assign req1_ready  = (state_q == ST_IDLE) && grant[1];
    assign owner_ready = own_q ? resp1_ready : resp0_ready;

    assign alu_op   = (state_q == ST_ISSUE) ? op_q   : '0;
    assign alu_src1 = (state_q == ST_ISSUE) ? src1_q : '0;
    assign alu_src2 = (state_q == ST_ISSUE) ? src2_q : '0;

    assign resp0_valid  = (state_q == ST_RESP) && !own_q;
    assign resp1_valid  = (state_q == ST_RESP) && own_q;
    assign resp0_result = own_q ? '0 : res_q;
    assign resp1_result = own_q ? res_q : '0;
    assign resp0_err    = !own_q && err_q;
    assign resp1_err    = own_q && err_q;
    assign flags        = flags_q;

    // Next-state: accept in IDLE, capture result and flags in ISSUE, wait for owner in RESP
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        own_d   = own_q;
        op_d    = op_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        res_d   = res_q;
        err_d   = err_q;
        flags_d = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    own_d   = grant[1];
                    last_d  = grant[1];
                    op_d    = grant[1] ? req1_op   : req0_op;
                    src1_d  = grant[1] ? req1_src1 : req0_src1;
                    src2_d  = grant[1] ? req1_src2 : req0_src2;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                res_d = alu_result;
                err_d = (op_q[OP_W-1:OP_W-2] == 2'b11);
                if (!own_q) begin
                    if (sets_znv(op_q)) begin
                        flags_d[FLAG_Z] = alu_flags[FLAG_Z];
                        flags_d[FLAG_V] = alu_flags[FLAG_V];
                        flags_d[FLAG_N] = alu_result[DATA_W-1];
                    end else if (sets_z(op_q)) begin
                        flags_d[FLAG_Z] = alu_flags[FLAG_Z];
                    end
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (owner_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scheduler state and issue/result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= ~FIRST_GRANT;
            own_q   <= 1'b0;
            op_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            own_q   <= own_d;
            op_q    <= op_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            res_q   <= res_d;
            err_q   <= err_d;
            flags_q <= flags_d;
        end
    end

`ifdef ALU_SCHED_PERF_EN
    logic [15:0] pg0_q, pg0_d, pg1_q, pg1_d, bp_q, bp_d;

    // Saturating counters: accepts per requester and stalled response cycles
    always_comb begin
        pg0_d = pg0_q;
        pg1_d = pg1_q;
        bp_d  = bp_q;
        if (req0_ready && (pg0_q != 16'hFFFF)) pg0_d = pg0_q + 16'd1;
        if (req1_ready && (pg1_q != 16'hFFFF)) pg1_d = pg1_q + 16'd1;
        if ((state_q == ST_RESP) && !owner_ready && (bp_q != 16'hFFFF)) bp_d = bp_q + 16'd1;
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pg0_q <= '0;
            pg1_q <= '0;
            bp_q  <= '0;
        end else begin
            pg0_q <= pg0_d;
            pg1_q <= pg1_d;
            bp_q  <= bp_d;
        end
    end

    assign perf_grant0 = pg0_q;
    assign perf_grant1 = pg1_q;
    assign perf_bp     = bp_q;
`endif

endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
- Two-requester scheduler that shares the single 16-bit ALU between the pipeline execute stage (requester 0) and the debug/self-test port (requester 1).
- Arbitrates round-robin, drives the ALU operand and opcode inputs from a registered issue slot, and captures the result.
- Returns the result to the owning requester over a valid/ready handshake.
- Owns the architectural flag register {Z,V,N}, which only requester 0 updates.

Parameters:
- OP_W, 4, ALU opcode width
- DATA_W, 16, operand/result width
- FIRST_GRANT, 0, requester that wins the first contended arbitration after reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  4  ALU opcode
- req0_src1  in  16  operand 1 (imm/shift amount/offset where applicable)
- req0_src2  in  16  operand 2
- req1_valid / req1_ready / req1_op / req1_src1 / req1_src2  same as requester 0
- resp0_valid  out  1  result for requester 0 available
- resp0_ready  in  1  requester 0 takes result
- resp0_result  out  16  result
- resp0_err  out  1  opcode was illegal (4'b1100..4'b1111)
- resp1_valid / resp1_ready / resp1_result / resp1_err  same as requester 0
- alu_op  out  4  to ALU opcode
- alu_src1  out  16  to ALU SrcData1
- alu_src2  out  16  to ALU SrcData2
- alu_result  in  16  from ALU Result
- alu_flags  in  3  from ALU Flags {Z,V,N}
- flags  out  3  architectural flag register {Z,V,N}

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: FSM=IDLE; every output 0 (ready, resp_valid, result, err, alu_op, alu_src1, alu_src2, flags=3'b000); last_grant = ~FIRST_GRANT.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready is asserted only in IDLE, and only to the granted requester (combinational).
  - Grant goes to the single valid requester. If both are valid, the grant goes to the requester that is not last_grant.
  - On accept, latch op, src1, src2 and owner into the issue register, update last_grant, and go to ISSUE.
- ISSUE (exactly one cycle):
  - alu_op, alu_src1 and alu_src2 are driven from the issue register. They hold 0 in every other state.
  - At the clock edge, capture alu_result into the result register.
  - Set err when op[3:2]==2'b11.
  - Apply the flag update (if the owner is requester 0), then go to RESP.
- RESP:
  - The owner's resp_valid=1; result and err are held stable.
  - Leave for IDLE when the owner's resp_ready=1.
  - No new grant while in RESP. The earliest next accept is the cycle after the handshake (3-cycle minimum issue interval).
  - resp_ready of the non-owner is ignored.
- Latency: accept at cycle N -> resp_valid at N+2.
- Flag update (owner 0 only; owner 1 never changes flags):
  - ADD 4'b1001, SUB 4'b1010: Z=alu_flags[2], V=alu_flags[1], N=alu_result[15].
  - XOR 4'b1011, SLL 4'b0001, SRA 4'b0010, ROR 4'b0100: Z=alu_flags[2] only; V and N hold.
  - All other opcodes, including illegal ones: flags hold.
- Illegal opcode: completes normally with result = alu_result (0 from ALU), err=1, no flag change.
- Boundary conditions:
  - Requester valid that drops while not granted: no effect.
  - A granted operation is never cancelled.
  - Reset mid-operation (any state): immediately IDLE, resp_valid=0, flags=0, and the operation is lost.

Optional Feature:
- Macro: ALU_SCHED_PERF_EN.
- Defined: adds outputs perf_grant0, perf_grant1 and perf_bp, each 16 bits, saturating at 16'hFFFF, reset to 0.
  - perf_grant0 / perf_grant1 count accepts per requester.
  - perf_bp counts RESP cycles with owner resp_ready=0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package alu_sched_pkg:
  - Opcode localparams: OP_RED=0, OP_SLL=1, OP_SRA=2, OP_PADDSB=3, OP_ROR=4, OP_LW=5, OP_SW=6, OP_LHB=7, OP_LLB=8, OP_ADD=9, OP_SUB=10, OP_XOR=11.
  - Flag indices FLAG_Z=2, FLAG_V=1, FLAG_N=0.
  - FSM state encoding.
  - Helper functions sets_znv(op) and sets_z(op).
- Sub-module rr_arb2: 2-way round-robin arbiter (valid0, valid1, last_grant -> grant one-hot).

Test Plan:
- Req0 ADD src1=16'h7FFF, src2=16'h0001 -> resp0_valid at N+2, resp0_result=16'h8000, flags=3'b011.
- Req0 SUB 16'h0005-16'h0005 -> result 16'h0000, flags=3'b100. Then req1 ADD 1+1 -> resp1_result=16'h0002, flags still 3'b100.
- Both valid with XOR ops, continuous -> grants alternate 0,1,0,1 (FIRST_GRANT=0). Each result is routed only to its owner's resp port.
- Req0 SLL with resp0_ready held low 3 cycles -> resp0_result stable for 4 cycles. req1_ready stays 0 throughout. Accept of pending req1 occurs the cycle after the handshake.
- Req0 op=4'b1110 -> resp0_err=1, result 16'h0000, flags unchanged.
- rst_n low during RESP of a req0 ADD -> resp0_valid=0 and flags=3'b000 immediately (asynchronous). After release, the next accept occurs normally.
